fighter_action_ctrl: RTL and testbench

FIGHTER_ACTION_CTRL -- requirements
Module: fighter_action_ctrl

---
 rtl/fighter_pkg.sv | 31 +++
 rtl/input_buffer.sv | 57 +++++
 rtl/fighter_action_ctrl.sv | 140 ++++++++++++++
 tb/tb_fighter_action_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fighter_pkg
// Description : Shared fighter state encodings and default frame counts,
//               used by the action controller and the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package fighter_pkg;

    typedef logic [2:0] fstate_t;

    localparam fstate_t c_ST_IDLE     = 3'd0;
    localparam fstate_t c_ST_STARTUP  = 3'd1;
    localparam fstate_t c_ST_ACTIVE   = 3'd2;
    localparam fstate_t c_ST_RECOVERY = 3'd3;
    localparam fstate_t c_ST_HITSTUN  = 3'd4;
    localparam fstate_t c_ST_KO       = 3'd5;

    localparam int c_DEF_STARTUP_FRAMES  = 4;
    localparam int c_DEF_ACTIVE_FRAMES   = 3;
    localparam int c_DEF_RECOVERY_FRAMES = 8;
    localparam int c_DEF_HITSTUN_FRAMES  = 12;
    localparam int c_DEF_BUFFER_FRAMES   = 6;

    // States in which a fresh attack press is held for later instead of dropped.
    function automatic logic is_bufferable(input fstate_t s);
        return (s == c_ST_ACTIVE) || (s == c_ST_RECOVERY);
    endfunction

endpackage : fighter_pkg
`default_nettype wire

// File: rtl/input_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_buffer
// Description : Attack-press edge detector plus a one-deep, time-limited
//               press buffer, all advanced on frame ticks only.
// Revision    : 1.0 - initial release
// ============================================================================
module input_buffer #(
    parameter int BUFFER_FRAMES = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic i_scen,
    input  logic i_btn_attack,
    input  logic i_arm_en,
    input  logic i_take_en,
    input  logic i_flush,
    output logic o_edge,
    output logic o_valid,
    output logic o_consume
);

    logic       r_prev;
    logic       r_valid;
    logic [4:0] r_age;

    assign o_edge    = i_scen & i_btn_attack & ~r_prev;
    assign o_valid   = r_valid;
    assign o_consume = i_scen & i_take_en & r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_valid <= 1'b0;
            r_age   <= 5'd0;
        end else if (i_scen) begin
            r_prev <= i_btn_attack;
            if (i_flush || o_consume) begin
                r_valid <= 1'b0;
                r_age   <= 5'd0;
            end else if (i_arm_en && o_edge) begin
                r_valid <= 1'b1;
                r_age   <= 5'd0;
            end else if (r_valid) begin
                // Usable on exactly BUFFER_FRAMES ticks after the press.
                if (r_age == 5'(BUFFER_FRAMES - 1)) begin
                    r_valid <= 1'b0;
                    r_age   <= 5'd0;
                end else begin
                    r_age <= r_age + 5'd1;
                end
            end
        end
    end

endmodule : input_buffer
`default_nettype wire

// File: rtl/fighter_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fighter_action_ctrl
// Description : Per-player action FSM: attack startup/active/recovery, hitstun
//               and KO, with movement gating toward the position mover.
// Revision    : 1.0 - initial release
// ============================================================================
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int STARTUP_FRAMES  = c_DEF_STARTUP_FRAMES,
    parameter int ACTIVE_FRAMES   = c_DEF_ACTIVE_FRAMES,
    parameter int RECOVERY_FRAMES = c_DEF_RECOVERY_FRAMES,
    parameter int HITSTUN_FRAMES  = c_DEF_HITSTUN_FRAMES,
    parameter int BUFFER_FRAMES   = c_DEF_BUFFER_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCEN,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       hit_taken,
    input  logic       ko,
    input  logic       jump_active,
    output logic       move_enable,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       hitbox_active,
    output logic [2:0] state,
    output logic       busy
);

    fstate_t    r_state;
    fstate_t    w_next_state;
    logic [4:0] r_cnt;
    logic       r_hitbox;
    logic       r_hit_pend;
    logic       w_restart;
    logic       w_load;
    logic       w_hit;
    logic       w_hit_apply;
    logic       w_take_en;
    logic       w_edge;
    logic       w_valid;
    logic       w_consume;
    logic       w_idle;

    assign w_hit       = hit_taken | r_hit_pend;
    assign w_hit_apply = w_hit & ~ko & (r_state != c_ST_KO);
    assign w_take_en   = (r_state == c_ST_IDLE) & ~jump_active & ~ko & ~w_hit;
    assign w_load      = (w_next_state != r_state) | w_restart;

    input_buffer #(
        .BUFFER_FRAMES(BUFFER_FRAMES)
    ) u_input_buffer (
        .clk          (clk),
        .reset        (reset),
        .i_scen       (SCEN),
        .i_btn_attack (btn_attack),
        .i_arm_en     (is_bufferable(r_state)),
        .i_take_en    (w_take_en),
        .i_flush      (SCEN & w_hit_apply),
        .o_edge       (w_edge),
        .o_valid      (w_valid),
        .o_consume    (w_consume)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= 5'd0;
            r_hitbox <= 1'b0;
        end else if (SCEN) begin
            r_state  <= w_next_state;
            r_cnt    <= w_load ? 5'd0 : r_cnt + 5'd1;
            r_hitbox <= (w_next_state == c_ST_ACTIVE);
        end
    end

    // A hit arriving between frame ticks waits for the next tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_pend <= 1'b0;
        end else if (SCEN) begin
            r_hit_pend <= 1'b0;
        end else if (hit_taken) begin
            r_hit_pend <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        if (ko || (r_state == c_ST_KO)) begin
            w_next_state = c_ST_KO;
        end else if (w_hit) begin
            w_next_state = c_ST_HITSTUN;
            w_restart    = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!jump_active && (w_edge || w_consume)) begin
                        w_next_state = c_ST_STARTUP;
                    end
                end
                c_ST_STARTUP: begin
                    if (r_cnt == 5'(STARTUP_FRAMES - 1)) w_next_state = c_ST_ACTIVE;
                end
                c_ST_ACTIVE: begin
                    if (r_cnt == 5'(ACTIVE_FRAMES - 1)) w_next_state = c_ST_RECOVERY;
                end
                c_ST_RECOVERY: begin
                    if (r_cnt == 5'(RECOVERY_FRAMES - 1)) w_next_state = c_ST_IDLE;
                end
                c_ST_HITSTUN: begin
                    if (r_cnt == 5'(HITSTUN_FRAMES - 1)) w_next_state = c_ST_IDLE;
                end
                default: w_next_state = c_ST_IDLE;
            endcase
        end
    end

    // Airborne arcs keep advancing through attacks and stun, but never in KO.
    always_comb begin
        w_idle      = (r_state == c_ST_IDLE);
        move_left   = w_idle & btn_left;
        move_right  = w_idle & btn_right;
        jump        = w_idle & btn_jump;
        move_enable = (r_state != c_ST_KO) & (w_idle | jump_active);
        busy        = ~w_idle;
    end

    assign hitbox_active = r_hitbox;
    assign state         = r_state;

endmodule : fighter_action_ctrl
`default_nettype wire

// File: tb/tb_fighter_action_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fighter_action_ctrl
// Description : Directed scenarios plus randomized run against a frame-level
//               reference model of the fighter action rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fighter_action_ctrl;

    localparam int S = 4;
    localparam int A = 3;
    localparam int R = 8;
    localparam int H = 12;
    localparam int B = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       SCEN = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic       btn_attack = 1'b0;
    logic       hit_taken = 1'b0;
    logic       ko = 1'b0;
    logic       jump_active = 1'b0;
    logic       move_enable;
    logic       move_left;
    logic       move_right;
    logic       jump;
    logic       hitbox_active;
    logic [2:0] state;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase code, frames remaining, buffer press frame.
    int m_st, m_rem, m_buf_f, m_frame;
    bit m_buf, m_prev, m_pend;

    fighter_action_ctrl #(
        .STARTUP_FRAMES (S),
        .ACTIVE_FRAMES  (A),
        .RECOVERY_FRAMES(R),
        .HITSTUN_FRAMES (H),
        .BUFFER_FRAMES  (B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .SCEN         (SCEN),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_jump     (btn_jump),
        .btn_attack   (btn_attack),
        .hit_taken    (hit_taken),
        .ko           (ko),
        .jump_active  (jump_active),
        .move_enable  (move_enable),
        .move_left    (move_left),
        .move_right   (move_right),
        .jump         (jump),
        .hitbox_active(hitbox_active),
        .state        (state),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    task automatic cyc(input logic s);
        SCEN = s;
        @(posedge clk);
        #1;
        SCEN      = 1'b0;
        hit_taken = 1'b0;
    endtask

    task automatic clear_inputs;
        btn_left = 0; btn_right = 0; btn_jump = 0; btn_attack = 0;
        hit_taken = 0; ko = 0; jump_active = 0; SCEN = 0;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic attack_edge;
        btn_attack = 1'b1;
        cyc(1);
        btn_attack = 1'b0;
    endtask

    task automatic test_reset;
        btn_left = 1; btn_jump = 1;
        #3;
        n_tests++;
        if (state !== 3'd0 || busy !== 1'b0 || hitbox_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d busy=%b hb=%b, need 0/0/0", state, busy, hitbox_active);
        end
        n_tests++;
        if (move_enable !== 1'b1 || move_left !== 1'b1 || move_right !== 1'b0 || jump !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_moves: me=%b l=%b r=%b j=%b, need 1/1/0/1", move_enable, move_left, move_right, jump);
        end
        reset = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_attack_timing;
        int exp_st;
        do_reset();
        attack_edge();
        n_tests++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL atk_start: state=%0d, need 1", state);
        end
        for (int k = 1; k <= S + A + R; k++) begin
            cyc(0);
            cyc(1);
            exp_st = (k < S) ? 1 : (k < S + A) ? 2 : (k < S + A + R) ? 3 : 0;
            n_tests++;
            if (state !== 3'(exp_st) || hitbox_active !== (exp_st == 2) || busy !== (exp_st != 0)) begin
                n_fail++;
                $display("FAIL atk_seq k=%0d: state=%0d hb=%b busy=%b, need %0d/%0b/%0b",
                         k, state, hitbox_active, busy, exp_st, exp_st == 2, exp_st != 0);
            end
        end
    endtask

    task automatic test_buffer;
        do_reset();
        attack_edge();
        for (int k = 1; k <= 31; k++) begin
            btn_attack = (k == S + A + 1 + 6);
            cyc(1);
            btn_attack = 1'b0;
            if (k == 15 || k == 16 || k == 31) begin
                n_tests++;
                if (state !== ((k == 16) ? 3'd1 : 3'd0)) begin
                    n_fail++;
                    $display("FAIL buf_late k=%0d: state=%0d, need %0d", k, state, (k == 16) ? 1 : 0);
                end
            end
        end
        cyc(1);
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL buf_consumed: state=%0d, need 0", state);
        end
        do_reset();
        attack_edge();
        for (int k = 1; k <= 20; k++) begin
            btn_attack = (k == S + A + 1);
            cyc(1);
            btn_attack = 1'b0;
            if (k >= 15) begin
                n_tests++;
                if (state !== 3'd0) begin
                    n_fail++;
                    $display("FAIL buf_expire k=%0d: state=%0d, need 0", k, state);
                end
            end
        end
    endtask

    task automatic test_hit;
        do_reset();
        attack_edge();
        for (int k = 1; k <= 5; k++) cyc(1);
        n_tests++;
        if (hitbox_active !== 1'b1 || state !== 3'd2) begin
            n_fail++;
            $display("FAIL hit_pre: state=%0d hb=%b, need 2/1", state, hitbox_active);
        end
        hit_taken = 1'b1;
        cyc(1);
        n_tests++;
        if (state !== 3'd4 || hitbox_active !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_enter: state=%0d hb=%b, need 4/0", state, hitbox_active);
        end
        for (int k = 1; k <= H + 1; k++) begin
            cyc(1);
            n_tests++;
            if (state !== ((k < H) ? 3'd4 : 3'd0)) begin
                n_fail++;
                $display("FAIL hit_stun k=%0d: state=%0d, need %0d", k, state, (k < H) ? 4 : 0);
            end
        end
        // latched off-tick hit, then a re-hit restarting the stun
        hit_taken = 1'b1;
        cyc(0);
        cyc(0);
        n_tests++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL hit_latch_hold: state=%0d, need 0", state);
        end
        cyc(1);
        n_tests++;
        if (state !== 3'd4) begin
            n_fail++;
            $display("FAIL hit_latch_apply: state=%0d, need 4", state);
        end
        for (int k = 1; k <= 5; k++) cyc(1);
        hit_taken = 1'b1;
        cyc(1);
        for (int k = 1; k <= H; k++) begin
            cyc(1);
            if (k == H - 1 || k == H) begin
                n_tests++;
                if (state !== ((k < H) ? 3'd4 : 3'd0)) begin
                    n_fail++;
                    $display("FAIL hit_restart k=%0d: state=%0d, need %0d", k, state, (k < H) ? 4 : 0);
                end
            end
        end
    endtask

    task automatic test_ko;
        do_reset();
        btn_left = 1; jump_active = 1;
        ko = 1; hit_taken = 1;
        cyc(1);
        ko = 0;
        n_tests++;
        if (state !== 3'd5 || move_enable !== 1'b0 || move_left !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ko_enter: state=%0d me=%b l=%b busy=%b, need 5/0/0/1", state, move_enable, move_left, busy);
        end
        for (int k = 0; k < 6; k++) begin
            btn_attack = k[0];
            hit_taken  = 1'b1;
            cyc(1);
        end
        n_tests++;
        if (state !== 3'd5 || move_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL ko_hold: state=%0d me=%b, need 5/0", state, move_enable);
        end
        clear_inputs();
        do_reset();
        n_tests++;
        if (state !== 3'd0 || move_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL ko_reset: state=%0d me=%b, need 0/1", state, move_enable);
        end
    endtask

    task automatic test_jump_hit;
        do_reset();
        btn_jump = 1;
        #1;
        n_tests++;
        if (jump !== 1'b1 || move_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL jh_idle: jump=%b me=%b, need 1/1", jump, move_enable);
        end
        jump_active = 1;
        for (int k = 0; k < 10; k++) cyc(1);
        btn_left = 1;
        hit_taken = 1;
        cyc(1);
        n_tests++;
        if (state !== 3'd4 || move_enable !== 1'b1 || jump !== 1'b0 || move_left !== 1'b0) begin
            n_fail++;
            $display("FAIL jh_stun: state=%0d me=%b j=%b l=%b, need 4/1/0/0", state, move_enable, jump, move_left);
        end
        for (int k = 0; k < 3; k++) cyc(1);
        jump_active = 0;
        #1;
        n_tests++;
        if (move_enable !== 1'b0 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL jh_land: me=%b state=%0d, need 0/4", move_enable, state);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        attack_edge();
        cyc(1);
        cyc(1);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (state !== 3'd0 || busy !== 1'b0 || hitbox_active !== 1'b0 || move_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_startup: state=%0d busy=%b hb=%b me=%b, need 0/0/0/1", state, busy, hitbox_active, move_enable);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        attack_edge();
        for (int k = 0; k < S; k++) cyc(1);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (hitbox_active !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_active: hb=%b state=%0d, need 0/0", hitbox_active, state);
        end
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic model_reset;
        m_st = 0; m_rem = 0; m_buf = 0; m_buf_f = 0;
        m_prev = 0; m_pend = 0; m_frame = 0;
    endtask

    task automatic model_step;
        bit e, h, live;
        int cur;
        if (!SCEN) begin
            if (hit_taken) m_pend = 1;
            return;
        end
        m_frame++;
        e      = btn_attack && !m_prev;
        m_prev = btn_attack;
        h      = hit_taken || m_pend;
        m_pend = 0;
        live   = m_buf && (m_frame - m_buf_f <= B);
        if (!live) m_buf = 0;
        cur = m_st;
        if (cur == 5) begin
        end else if (ko) begin
            m_st = 5;
        end else if (h) begin
            m_st = 4; m_rem = H; m_buf = 0;
        end else if (cur == 0) begin
            if (!jump_active && (e || live)) begin
                m_st = 1; m_rem = S; m_buf = 0;
            end
        end else begin
            if ((cur == 2 || cur == 3) && e) begin
                m_buf = 1; m_buf_f = m_frame;
            end
            m_rem--;
            if (m_rem == 0) begin
                case (cur)
                    1: begin m_st = 2; m_rem = A; end
                    2: begin m_st = 3; m_rem = R; end
                    default: m_st = 0;
                endcase
            end
        end
    endtask

    task automatic test_random;
        bit e_hb, e_busy, e_me, e_l, e_r, e_j;
        clear_inputs();
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_st == 5 && ($urandom % 20 == 0)) begin
                clear_inputs();
                do_reset();
                model_reset();
            end
            SCEN      = ($urandom % 2 == 0);
            btn_left  = $urandom % 2;
            btn_right = $urandom % 2;
            btn_jump  = $urandom % 2;
            if ($urandom % 4 == 0) btn_attack = ~btn_attack;
            hit_taken = ($urandom % 30 == 0);
            ko        = ($urandom % 400 == 0);
            if ($urandom % 10 == 0) jump_active = ~jump_active;
            model_step();
            @(posedge clk);
            #1;
            e_hb   = (m_st == 2);
            e_busy = (m_st != 0);
            e_me   = (m_st != 5) && (m_st == 0 || jump_active);
            e_l    = (m_st == 0) && btn_left;
            e_r    = (m_st == 0) && btn_right;
            e_j    = (m_st == 0) && btn_jump;
            n_tests++;
            if (state !== 3'(m_st) || hitbox_active !== e_hb || busy !== e_busy ||
                move_enable !== e_me || move_left !== e_l || move_right !== e_r || jump !== e_j) begin
                n_fail++;
                $display("FAIL random i=%0d: st=%0d hb=%b busy=%b me=%b l=%b r=%b j=%b, need st=%0d hb=%b busy=%b me=%b l=%b r=%b j=%b",
                         i, state, hitbox_active, busy, move_enable, move_left, move_right, jump,
                         m_st, e_hb, e_busy, e_me, e_l, e_r, e_j);
            end
            SCEN = 0;
            hit_taken = 0;
        end
    endtask

    initial begin
        test_reset();
        test_attack_timing();
        test_buffer();
        test_hit();
        test_ko();
        test_jump_hit();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fighter_action_ctrl
`default_nettype wire
